rr_grant_arbiter: RTL and testbench



---
 rtl/rr_grant_arbiter_pkg.sv | 20 ++
 rtl/rr_grant_arbiter_pick.sv | 53 +++++
 rtl/rr_grant_arbiter.sv | 121 ++++++++++++
 tb/tb_rr_grant_arbiter.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/rr_grant_arbiter_pkg.sv
//==============================================================================
// Package : arb_pkg
// Brief   : Shared state encoding and default sizing for rr_grant_arbiter.
// Rev     : 1.0
//==============================================================================
`default_nettype none

package arb_pkg;

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } arb_state_t;

   localparam int ARB_N_REQ    = 4;
   localparam int ARB_MAX_HOLD = 16;

endpackage : arb_pkg

`default_nettype wire

// File: rtl/rr_grant_arbiter_pick.sv
//==============================================================================
// Module : rr_pick
// Brief  : Combinational round-robin winner search starting at ptr.
// Rev    : 1.0
//==============================================================================
`default_nettype none

module rr_pick
   import arb_pkg::*;
#(
   parameter int N_REQ = ARB_N_REQ,
   parameter int IDW   = $clog2(N_REQ)
) (
   input  logic [N_REQ-1:0] req,
   input  logic [IDW-1:0]   ptr,
   output logic [N_REQ-1:0] win_oh,
   output logic [IDW-1:0]   win_id,
   output logic             hit
);

   logic [2*N_REQ-1:0] dbl;
   logic [N_REQ-1:0]   rot;
   int                 off;
   int                 sum;

   // Duplicating the vector turns the wrap-around search into a plain slice.
   assign dbl = {req, req};
   assign rot = dbl[ptr +: N_REQ];

   always_comb begin
      hit    = 1'b0;
      off    = 0;
      sum    = 0;
      win_oh = '0;
      for (int j = N_REQ - 1; j >= 0; j--) begin
         if (rot[j]) begin
            hit = 1'b1;
            off = j;
         end
      end
      sum = int'(ptr) + off;
      if (sum >= N_REQ) begin
         sum = sum - N_REQ;
      end
      win_id = IDW'(sum);
      if (hit) begin
         win_oh[win_id] = 1'b1;
      end
   end

endmodule : rr_pick

`default_nettype wire

// File: rtl/rr_grant_arbiter.sv
//==============================================================================
// Module : rr_grant_arbiter
// Brief  : Round-robin single-grant arbiter with bounded hold time.
// Rev    : 1.0
//==============================================================================
`default_nettype none

module rr_grant_arbiter
   import arb_pkg::*;
#(
   parameter int N_REQ    = ARB_N_REQ,
   parameter int MAX_HOLD = ARB_MAX_HOLD,
   parameter int IDW      = $clog2(N_REQ)
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [N_REQ-1:0] req,
   output logic [N_REQ-1:0] gnt,
   output logic [IDW-1:0]   gnt_id,
   output logic             gnt_valid,
   output logic             timeout
);

   localparam int CW = $clog2(MAX_HOLD + 1);

   arb_state_t       state_q, state_d;
   logic [N_REQ-1:0] gnt_q, gnt_d;
   logic [IDW-1:0]   gnt_id_q, gnt_id_d;
   logic             gnt_valid_q, gnt_valid_d;
   logic             timeout_q, timeout_d;
   logic [IDW-1:0]   ptr_q, ptr_d;
   logic [CW-1:0]    cnt_q, cnt_d;

   logic [IDW-1:0]   ptr_after;
   logic [N_REQ-1:0] pick_oh;
   logic [IDW-1:0]   pick_id;
   logic             pick_hit;

   rr_pick #(
      .N_REQ (N_REQ),
      .IDW   (IDW)
   ) u_pick (
      .req    (req),
      .ptr    (ptr_q),
      .win_oh (pick_oh),
      .win_id (pick_id),
      .hit    (pick_hit)
   );

   // The departing owner drops to lowest priority on the next search.
   assign ptr_after = (gnt_id_q == IDW'(N_REQ - 1)) ? '0 : gnt_id_q + IDW'(1);

   always_comb begin
      state_d     = state_q;
      gnt_d       = gnt_q;
      gnt_id_d    = gnt_id_q;
      gnt_valid_d = gnt_valid_q;
      timeout_d   = 1'b0;
      ptr_d       = ptr_q;
      cnt_d       = cnt_q;
      case (state_q)
         IDLE: begin
            gnt_d       = '0;
            gnt_id_d    = '0;
            gnt_valid_d = 1'b0;
            if (pick_hit) begin
               state_d     = GRANT;
               gnt_d       = pick_oh;
               gnt_id_d    = pick_id;
               gnt_valid_d = 1'b1;
               cnt_d       = '0;
            end
         end
         GRANT: begin
            if (!req[gnt_id_q] || (cnt_q == CW'(MAX_HOLD - 1))) begin
               // A dropped request wins over a coincident hold expiry: no timeout.
               timeout_d   = req[gnt_id_q];
               state_d     = IDLE;
               gnt_d       = '0;
               gnt_id_d    = '0;
               gnt_valid_d = 1'b0;
               ptr_d       = ptr_after;
               cnt_d       = '0;
            end else if (cnt_q != CW'(MAX_HOLD)) begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         gnt_q       <= '0;
         gnt_id_q    <= '0;
         gnt_valid_q <= 1'b0;
         timeout_q   <= 1'b0;
         ptr_q       <= '0;
         cnt_q       <= '0;
      end else begin
         state_q     <= state_d;
         gnt_q       <= gnt_d;
         gnt_id_q    <= gnt_id_d;
         gnt_valid_q <= gnt_valid_d;
         timeout_q   <= timeout_d;
         ptr_q       <= ptr_d;
         cnt_q       <= cnt_d;
      end
   end

   assign gnt       = gnt_q;
   assign gnt_id    = gnt_id_q;
   assign gnt_valid = gnt_valid_q;
   assign timeout   = timeout_q;

endmodule : rr_grant_arbiter

`default_nettype wire

// File: tb/tb_rr_grant_arbiter.sv
//==============================================================================
// Module : tb_rr_grant_arbiter
// Brief  : Directed self-checking bench for rr_grant_arbiter (4x4 and 2x1).
// Rev    : 1.0
//==============================================================================
`default_nettype none

module tb_rr_grant_arbiter;

   logic       clk;
   logic       rst_a, rst_b;
   logic [3:0] req_a;
   logic [3:0] gnt_a;
   logic [1:0] gnt_id_a;
   logic       gnt_valid_a, timeout_a;
   logic [1:0] req_b;
   logic [1:0] gnt_b;
   logic [0:0] gnt_id_b;
   logic       gnt_valid_b, timeout_b;

   int tests;
   int fails;

   rr_grant_arbiter #(
      .N_REQ    (4),
      .MAX_HOLD (4)
   ) dut_a (
      .clock     (clk),
      .reset     (rst_a),
      .req       (req_a),
      .gnt       (gnt_a),
      .gnt_id    (gnt_id_a),
      .gnt_valid (gnt_valid_a),
      .timeout   (timeout_a)
   );

   rr_grant_arbiter #(
      .N_REQ    (2),
      .MAX_HOLD (1)
   ) dut_b (
      .clock     (clk),
      .reset     (rst_b),
      .req       (req_b),
      .gnt       (gnt_b),
      .gnt_id    (gnt_id_b),
      .gnt_valid (gnt_valid_b),
      .timeout   (timeout_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   initial begin
      int owner;
      int pos;
      tests = 0;
      fails = 0;
      rst_a = 1'b1;
      rst_b = 1'b1;
      req_a = 4'b0000;
      req_b = 2'b00;

      // Reset state
      #2;
      check("rst_gnt", 32'(gnt_a), 32'h0);
      check("rst_gnt_id", 32'(gnt_id_a), 32'h0);
      check("rst_valid", 32'(gnt_valid_a), 32'h0);
      check("rst_timeout", 32'(timeout_a), 32'h0);
      tick();
      rst_a = 1'b0;

      // Basic grant, release, dead cycle, next grant
      req_a = 4'b0101;
      tick();
      check("first_gnt", 32'(gnt_a), 32'h1);
      check("first_id", 32'(gnt_id_a), 32'h0);
      check("first_valid", 32'(gnt_valid_a), 32'h1);
      req_a = 4'b0100;
      tick();
      check("release_gnt", 32'(gnt_a), 32'h0);
      check("release_valid", 32'(gnt_valid_a), 32'h0);
      check("release_no_to", 32'(timeout_a), 32'h0);
      tick();
      check("second_gnt", 32'(gnt_a), 32'h4);
      check("second_id", 32'(gnt_id_a), 32'h2);

      // No preemption: req[0] rises while agent 2 owns
      req_a = 4'b0101;
      tick();
      check("nopre_1", 32'(gnt_a), 32'h4);
      tick();
      check("nopre_2", 32'(gnt_a), 32'h4);
      req_a = 4'b0001;
      tick();
      check("nopre_rel", 32'(gnt_a), 32'h0);
      tick();
      check("nopre_next", 32'(gnt_a), 32'h1);

      // Pointer wrap 3 -> 0 -> 1
      req_a = 4'b0000;
      tick();
      check("wrap_idle0", 32'(gnt_a), 32'h0);
      req_a = 4'b0100;
      tick();
      check("wrap_srv2", 32'(gnt_a), 32'h4);
      req_a = 4'b0000;
      tick();
      check("wrap_idle1", 32'(gnt_a), 32'h0);
      req_a = 4'b0110;
      tick();
      check("wrap_gnt", 32'(gnt_a), 32'h2);
      check("wrap_id", 32'(gnt_id_a), 32'h1);

      // Full contention rotation from a fresh pointer
      req_a = 4'b0000;
      rst_a = 1'b1;
      tick();
      rst_a = 1'b0;
      req_a = 4'b1111;
      for (int c = 1; c <= 100; c++) begin
         tick();
         pos   = (c - 1) % 5;
         owner = ((c - 1) / 5) % 4;
         check("rot_gnt", 32'(gnt_a), (pos < 4) ? (32'h1 << owner) : 32'h0);
         check("rot_valid", 32'(gnt_valid_a), (pos < 4) ? 32'h1 : 32'h0);
         check("rot_timeout", 32'(timeout_a), (pos == 4) ? 32'h1 : 32'h0);
      end

      // Asynchronous reset in the middle of a grant
      tick();
      check("mid_gnt", 32'(gnt_a), 32'h1);
      #3;
      rst_a = 1'b1;
      #1;
      check("async_gnt", 32'(gnt_a), 32'h0);
      check("async_valid", 32'(gnt_valid_a), 32'h0);
      req_a = 4'b1010;
      tick();
      rst_a = 1'b0;
      tick();
      check("post_rst_gnt", 32'(gnt_a), 32'h2);
      check("post_rst_id", 32'(gnt_id_a), 32'h1);
      req_a = 4'b1000;
      tick();
      check("post_rst_rel", 32'(gnt_a), 32'h0);
      tick();
      check("post_rst_g3", 32'(gnt_a), 32'h8);
      check("post_rst_id3", 32'(gnt_id_a), 32'h3);

      // Two agents, single-cycle hold
      tick();
      rst_b = 1'b0;
      req_b = 2'b11;
      for (int c = 1; c <= 12; c++) begin
         tick();
         if (c % 2 == 1) begin
            owner = ((c - 1) / 2) % 2;
            check("b_gnt", 32'(gnt_b), 32'h1 << owner);
            check("b_id", 32'(gnt_id_b), 32'(owner));
            check("b_timeout", 32'(timeout_b), 32'h0);
         end else begin
            check("b_gnt_idle", 32'(gnt_b), 32'h0);
            check("b_timeout", 32'(timeout_b), 32'h1);
         end
      end
      req_b = 2'b01;
      tick();
      check("b_single", 32'(gnt_b), 32'h1);
      req_b = 2'b00;
      tick();
      check("b_rel_gnt", 32'(gnt_b), 32'h0);
      check("b_rel_no_to", 32'(timeout_b), 32'h0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule : tb_rr_grant_arbiter

`default_nettype wire
